// File: rtl/cva6_region_cfg_pkg.sv
// Shared types for the runtime region configuration unit.
package cva6_region_cfg_pkg;

  localparam int unsigned RegionAttrWidth = 3;

  typedef enum logic [1:0] {
    BASE = 2'd0,
    LEN  = 2'd1,
    ATTR = 2'd2,
    LOCK = 2'd3
  } region_field_e;

  typedef struct packed {
    logic nonidem;
    logic cached;
    logic exec;
  } region_attr_t;

endpackage

// File: rtl/cva6_region_match.sv
// Combinational match of one address against all region rules.
// The lowest-indexed matching rule supplies the attributes.
module cva6_region_match
  import cva6_region_cfg_pkg::*;
#(
  parameter int unsigned NrRules   = 4,
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0]              addr,
  input  logic [NrRules-1:0][AddrWidth-1:0] base,
  input  logic [NrRules-1:0][AddrWidth-1:0] len,
  input  region_attr_t [NrRules-1:0]        attr,
  output logic                              hit,
  output region_attr_t                      attr_out
);

  logic [NrRules-1:0]                match;
  logic [NrRules-1:0][AddrWidth-1:0] offset;

  // Per-rule window test; comparing the offset against len stays correct when base+len wraps.
  always_comb begin
    for (int r = 0; r < int'(NrRules); r++) begin
      offset[r] = addr - base[r];
      match[r]  = (len[r] != '0) && (addr >= base[r]) && (offset[r] < len[r]);
    end
  end

  // Scan from the top so the last assignment comes from the lowest matching rule.
  always_comb begin
    hit      = |match;
    attr_out = '0;
    for (int r = int'(NrRules) - 1; r >= 0; r--) begin
      if (match[r]) attr_out = attr[r];
    end
  end

endmodule

// File: rtl/cva6_region_cfg_unit.sv
// Runtime-programmable execute/cached/non-idempotent region rules.
// Config port: same-cycle grant, registered response one cycle later.
// Lookups: NrLkpPorts independent channels with one cycle of latency.
// Optional feature: define CVA6_REGION_CFG_PERF_EN to enable the saturating
// lookup-miss counter on perf_miss_cnt_o; otherwise that output is tied to 0.
module cva6_region_cfg_unit
  import cva6_region_cfg_pkg::*;
#(
  parameter int unsigned NrRules    = 4,
  parameter int unsigned NrLkpPorts = 2,
  parameter int unsigned AddrWidth  = 64,
  parameter logic [NrRules*AddrWidth-1:0]       RstBase = '0,
  parameter logic [NrRules*AddrWidth-1:0]       RstLen  = '0,
  parameter logic [NrRules*RegionAttrWidth-1:0] RstAttr = '0,
  parameter logic [NrRules-1:0]                 RstLock = '0,
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             cfg_req_i,
  input  logic                             cfg_we_i,
  input  logic [IdxWidth-1:0]              cfg_idx_i,
  input  logic [1:0]                       cfg_field_i,
  input  logic [AddrWidth-1:0]             cfg_wdata_i,
  output logic                             cfg_gnt_o,
  output logic                             cfg_rvalid_o,
  output logic [AddrWidth-1:0]             cfg_rdata_o,
  output logic                             cfg_err_o,
  input  logic [NrLkpPorts-1:0]            lkp_valid_i,
  input  logic [NrLkpPorts*AddrWidth-1:0]  lkp_addr_i,
  output logic [NrLkpPorts-1:0]            lkp_valid_o,
  output logic [NrLkpPorts-1:0]            lkp_hit_o,
  output logic [NrLkpPorts-1:0]            lkp_exec_o,
  output logic [NrLkpPorts-1:0]            lkp_cached_o,
  output logic [NrLkpPorts-1:0]            lkp_nonidem_o,
  output logic [31:0]                      perf_miss_cnt_o
);

  logic [NrRules-1:0][AddrWidth-1:0] base_q;
  logic [NrRules-1:0][AddrWidth-1:0] len_q;
  region_attr_t [NrRules-1:0]        attr_q;
  logic [NrRules-1:0]                lock_q;

  region_field_e          field;
  logic                   idx_ok;
  logic                   sel_locked;
  logic                   wr_err;
  logic [AddrWidth-1:0]   rd_data;
  logic                   rvalid_q;
  logic                   err_q;
  logic [AddrWidth-1:0]   rdata_q;

  logic [NrLkpPorts-1:0]     hit;
  region_attr_t [NrLkpPorts-1:0] match_attr;
  logic [NrLkpPorts-1:0]     valid_q;
  logic [NrLkpPorts-1:0]     hit_q;
  logic [NrLkpPorts-1:0]     exec_q;
  logic [NrLkpPorts-1:0]     cached_q;
  logic [NrLkpPorts-1:0]     nonidem_q;

  assign field     = region_field_e'(cfg_field_i);
  assign idx_ok    = (32'(cfg_idx_i) < NrRules);
  assign cfg_gnt_o = cfg_req_i;

  // Clearing a lock is a silent no-op, so it never reports an error even on a locked rule.
  always_comb begin
    sel_locked = idx_ok ? lock_q[cfg_idx_i] : 1'b0;
    wr_err     = !idx_ok || (sel_locked && !((field == LOCK) && !cfg_wdata_i[0]));
  end

  // Read mux; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    if (idx_ok) begin
      case (field)
        BASE:    rd_data = base_q[cfg_idx_i];
        LEN:     rd_data = len_q[cfg_idx_i];
        ATTR:    rd_data[RegionAttrWidth-1:0] = attr_q[cfg_idx_i];
        LOCK:    rd_data[0] = lock_q[cfg_idx_i];
        default: rd_data = '0;
      endcase
    end
  end

  // Rule storage and registered config response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q   <= RstBase;
      len_q    <= RstLen;
      attr_q   <= RstAttr;
      lock_q   <= RstLock;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cfg_req_i;
      if (cfg_req_i) begin
        rdata_q <= cfg_we_i ? '0 : rd_data;
        err_q   <= cfg_we_i ? wr_err : !idx_ok;
        if (cfg_we_i && !wr_err) begin
          case (field)
            BASE:    base_q[cfg_idx_i] <= cfg_wdata_i;
            LEN:     len_q[cfg_idx_i]  <= cfg_wdata_i;
            ATTR:    attr_q[cfg_idx_i] <= region_attr_t'(cfg_wdata_i[RegionAttrWidth-1:0]);
            LOCK:    if (cfg_wdata_i[0]) lock_q[cfg_idx_i] <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_err_o    = err_q;
  assign cfg_rdata_o  = rdata_q;

  for (genvar p = 0; p < NrLkpPorts; p++) begin : g_port
    cva6_region_match #(
      .NrRules   (NrRules),
      .AddrWidth (AddrWidth)
    ) i_match (
      .addr     (lkp_addr_i[p*AddrWidth +: AddrWidth]),
      .base     (base_q),
      .len      (len_q),
      .attr     (attr_q),
      .hit      (hit[p]),
      .attr_out (match_attr[p])
    );
  end

  // Lookup results register; attributes only update on a valid lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      hit_q     <= '0;
      exec_q    <= '0;
      cached_q  <= '0;
      nonidem_q <= '0;
    end else begin
      valid_q <= lkp_valid_i;
      for (int p = 0; p < int'(NrLkpPorts); p++) begin
        if (lkp_valid_i[p]) begin
          hit_q[p]     <= hit[p];
          exec_q[p]    <= match_attr[p].exec;
          cached_q[p]  <= match_attr[p].cached;
          nonidem_q[p] <= match_attr[p].nonidem;
        end
      end
    end
  end

  assign lkp_valid_o   = valid_q;
  assign lkp_hit_o     = hit_q;
  assign lkp_exec_o    = exec_q;
  assign lkp_cached_o  = cached_q;
  assign lkp_nonidem_o = nonidem_q;

`ifdef CVA6_REGION_CFG_PERF_EN
  logic [31:0] miss_cnt_q;
  logic [32:0] miss_sum;

  // Sum of missing valid lookups this cycle; bit 32 flags overflow for saturation.
  always_comb begin
    miss_sum = {1'b0, miss_cnt_q};
    for (int p = 0; p < int'(NrLkpPorts); p++) begin
      miss_sum = miss_sum + 33'(lkp_valid_i[p] && !hit[p]);
    end
  end

  // Saturating miss counter, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      miss_cnt_q <= '0;
    end else begin
      miss_cnt_q <= miss_sum[32] ? 32'hFFFF_FFFF : miss_sum[31:0];
    end
  end

  assign perf_miss_cnt_o = miss_cnt_q;
`else
  assign perf_miss_cnt_o = '0;
`endif

endmodule

// File: doc/cva6_region_cfg_unit.md
Name: cva6_region_cfg_unit

Overview:
Runtime-programmable successor to the compile-time execute/cached/non-idempotent region rules in the core config package.
- Holds NrRules address regions, each with a 3-bit attribute set.
- Programmed over a simple request/grant config port; rules can be locked individually.
- Answers NrLkpPorts independent address lookups with registered 1-cycle latency.
- Sits beside the PMP/MMU stage, feeding the fetch/LSU cacheability and execute-permission checks.

Parameters:
- NrRules, 4, number of region rules (1..16).
- NrLkpPorts, 2, independent lookup channels (1..4).
- AddrWidth, 64, address/length width.
- RstBase, '0, NrRules*AddrWidth packed reset bases, rule 0 in LSBs.
- RstLen, '0, NrRules*AddrWidth packed reset lengths.
- RstAttr, '0, NrRules*3 packed reset attributes.
- RstLock, '0, NrRules reset lock bits.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_req_i  in  1  config access request.
- cfg_we_i  in  1  1=write, 0=read.
- cfg_idx_i  in  $clog2(NrRules) (min 1)  rule index.
- cfg_field_i  in  2  0=base, 1=len, 2=attr, 3=lock.
- cfg_wdata_i  in  AddrWidth  write data.
- cfg_gnt_o  out  1  grant (same cycle).
- cfg_rvalid_o  out  1  response valid.
- cfg_rdata_o  out  AddrWidth  read data, zero-extended.
- cfg_err_o  out  1  error, qualified by rvalid.
- lkp_valid_i  in  NrLkpPorts  lookup valid per port.
- lkp_addr_i  in  NrLkpPorts*AddrWidth  lookup addresses.
- lkp_valid_o  out  NrLkpPorts  result valid.
- lkp_hit_o  out  NrLkpPorts  any rule matched.
- lkp_exec_o  out  NrLkpPorts  executable.
- lkp_cached_o  out  NrLkpPorts  cacheable.
- lkp_nonidem_o  out  NrLkpPorts  non-idempotent.
- perf_miss_cnt_o  out  32  lookups with no hit.

Behaviour:
- Reset (async assert, sync deassert):
  - base/len/attr/lock take the Rst* parameters.
  - All registered outputs reset to 0.
  - No pending response survives reset; a config or lookup in flight when reset asserts is dropped.
- Config grant:
  - cfg_gnt_o = cfg_req_i (combinational, never stalls).
  - Response is registered: cfg_rvalid_o=1 exactly one cycle after each grant.
- Reads:
  - base/len return the full value.
  - attr returns {nonidem,cached,exec} in bits [2:0].
  - lock returns bit 0.
  - cfg_err_o=0.
  - cfg_idx_i >= NrRules: rdata=0, err=1.
- Writes:
  - Take effect at the next clock edge.
  - attr uses wdata[2:0]. lock uses wdata[0]; lock can only be set, and writing 0 is ignored without error.
  - Write to a locked rule, or idx >= NrRules: no state change, err=1.
  - Write to an unlocked rule: err=0.
- Match rule r: len[r]!=0 && addr>=base[r] && (addr-base[r]) < len[r].
  - All arithmetic unsigned AddrWidth.
  - The subtract form avoids overflow when base+len wraps past 2^AddrWidth.
  - len=0 disables the rule.
- Priority: lowest matching index supplies the attributes. hit=1 if any rule matches.
- No match: hit=exec=cached=nonidem=0.
- Lookup timing:
  - lkp_* outputs registered; a valid lookup in cycle N gives lkp_valid_o=1 in N+1.
  - Attribute outputs hold their last value when valid_o=0.
- Write and lookup in the same cycle: the lookup sees the OLD rule state. A lookup in the following cycle sees the new state.
- Ports are fully independent; identical addresses on all ports give identical results.

Optional Feature:
- CVA6_REGION_CFG_PERF_EN defined: perf_miss_cnt_o is a 32-bit counter.
  - Increments by the number of ports with lkp_valid_i=1 and no match in the cycle.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by reset.
- Undefined: perf_miss_cnt_o tied to 0; no counter flops.

Decomposition:
- Package cva6_region_cfg_pkg:
  - enum region_field_e (BASE, LEN, ATTR, LOCK).
  - packed struct region_attr_t {nonidem, cached, exec}.
  - constant RegionAttrWidth=3.
- Sub-module cva6_region_match: combinational.
  - One address against all rules.
  - Outputs hit plus prioritised region_attr_t.
  - Instantiated NrLkpPorts times.

Test Plan:
- Reset with RstBase rule0=0x8000_0000, RstLen=0x4000_0000, RstAttr=3'b011: lookup 0x8000_0010 -> next cycle valid=1, hit=1, exec=1, cached=1, nonidem=0. Lookup 0xC000_0000 -> hit=0.
- Write rule1 base=0x1_0000, len=0x1_0000, attr=3'b100; lookup 0x1_0004 in the same cycle -> hit=0 (old state). Repeat next cycle -> hit=1, nonidem=1.
- Lock rule1, then write its len=0x20 -> rvalid=1, err=1; readback len=0x1_0000. Write lock=0 -> err=0, lock still 1.
- Overlap: rule0 attr=3'b001 and rule2 attr=3'b110 over the same range -> result exec=1, cached=0 (rule0 wins).
- Wrap: base=64'hFFFF_FFFF_FFFF_FF00, len=0x200; lookup 64'h10 -> hit=0. Lookup 64'hFFFF_FFFF_FFFF_FFF0 -> hit=1.
- With CVA6_REGION_CFG_PERF_EN: 2 ports missing for 5 cycles -> perf_miss_cnt_o=10. Assert rst_ni mid-run -> 0 immediately.
